// File: rtl/phj_phase_sequencer.sv
// Phase controller for the partitioned hash join pipeline.
// Sequences IDLE -> BUILD -> BUILD_DRAIN -> PROBE -> FLUSH -> DONE. It gates
// the per-lane build and probe valid/ready handshakes so that no probe tuple
// reaches the hash tables before every partition has finished building. It
// also counts the tuples accepted in each phase and pulses done once the final
// output beat has left the stream-to-AXI converter.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, abort          single-cycle job start, synchronous job abort
//   build_in_*/out_*      build stream valid/ready, converter <-> build hasher
//   probe_in_*/out_*      probe stream valid/ready, converter <-> probe hasher
//   build_last_processed  per-table "build finished" indication (level or pulse)
//   probe_last_processed  per-storage "probe finished" indication (level or pulse)
//   out_last_beat         final AXI output beat handshake
//   phase, busy, done     encoded state, not-idle flag, one-cycle completion pulse
//   build_cnt, probe_cnt  saturating counts of tuples accepted in this job
module phj_phase_sequencer #(
  parameter int unsigned NUM_PART     = 8,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_PART-1:0] build_in_valid,
  output logic [NUM_PART-1:0] build_in_ready,
  output logic [NUM_PART-1:0] build_out_valid,
  input  logic [NUM_PART-1:0] build_out_ready,
  input  logic [NUM_PART-1:0] probe_in_valid,
  output logic [NUM_PART-1:0] probe_in_ready,
  output logic [NUM_PART-1:0] probe_out_valid,
  input  logic [NUM_PART-1:0] probe_out_ready,
  input  logic [NUM_PART-1:0] build_last_processed,
  input  logic [NUM_PART-1:0] probe_last_processed,
  input  logic                out_last_beat,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    build_cnt,
  output logic [CNT_W-1:0]    probe_cnt
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_BUILD       = 3'd1;
  localparam logic [2:0] S_BUILD_DRAIN = 3'd2;
  localparam logic [2:0] S_PROBE       = 3'd3;
  localparam logic [2:0] S_FLUSH       = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam int unsigned PC_W    = $clog2(NUM_PART + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam bit          SKIP_DRAIN = (DRAIN_CYCLES == 0);

  localparam logic [NUM_PART-1:0] LANES_ALL = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  logic [2:0]          state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [NUM_PART-1:0] build_mask_q, build_mask_d;
  logic [NUM_PART-1:0] probe_mask_q, probe_mask_d;
  logic                last_seen_q, last_seen_d;
  logic [CNT_W-1:0]    build_cnt_q, build_cnt_d;
  logic [CNT_W-1:0]    probe_cnt_q, probe_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                build_open_c, probe_open_c;
  logic                build_all_c, probe_all_c;

  // Number of lanes set in a lane vector.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_PART-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_PART; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Gates: abort closes them in the same cycle it is raised.
  assign build_open_c = (state_q == S_BUILD) && !abort;
  assign probe_open_c = (state_q == S_PROBE) && !abort;

  assign build_out_valid = build_open_c ? build_in_valid  : '0;
  assign build_in_ready  = build_open_c ? build_out_ready : '0;
  assign probe_out_valid = probe_open_c ? probe_in_valid  : '0;
  assign probe_in_ready  = probe_open_c ? probe_out_ready : '0;

  // A last indication arriving in the checking cycle counts toward completion.
  assign build_all_c = ((build_mask_q | build_last_processed) == LANES_ALL);
  assign probe_all_c = ((probe_mask_q | probe_last_processed) == LANES_ALL);

  // Next-state, masks, drain counter and tuple counters.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    build_mask_d = build_mask_q;
    probe_mask_d = probe_mask_q;
    last_seen_d  = last_seen_q;
    build_cnt_d  = sat_add(build_cnt_q, popcount(build_out_valid & build_out_ready));
    probe_cnt_d  = sat_add(probe_cnt_q, popcount(probe_out_valid & probe_out_ready));

    if (state_q == S_BUILD) begin
      build_mask_d = build_mask_q | build_last_processed;
    end
    if (state_q == S_PROBE) begin
      probe_mask_d = probe_mask_q | probe_last_processed;
    end
    if (((state_q == S_PROBE) || (state_q == S_FLUSH)) && out_last_beat) begin
      last_seen_d = 1'b1;
    end

    if (abort) begin
      // Counters keep their values so software can inspect an aborted job.
      state_d      = S_IDLE;
      drain_d      = '0;
      build_mask_d = '0;
      probe_mask_d = '0;
      last_seen_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d      = S_BUILD;
            drain_d      = '0;
            build_mask_d = '0;
            probe_mask_d = '0;
            last_seen_d  = 1'b0;
            build_cnt_d  = '0;
            probe_cnt_d  = '0;
          end
        end
        S_BUILD: begin
          if (build_all_c) begin
            if (SKIP_DRAIN) begin
              state_d = S_PROBE;
            end else begin
              state_d = S_BUILD_DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        S_BUILD_DRAIN: begin
          // Loaded with DRAIN_CYCLES; leaves on the cycle it reads 1.
          drain_d = drain_q - DRAIN_W'(1);
          if (drain_q == DRAIN_W'(1)) begin
            state_d = S_PROBE;
          end
        end
        S_PROBE: begin
          if (probe_all_c) begin
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (last_seen_q || out_last_beat) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      build_mask_q <= '0;
      probe_mask_q <= '0;
      last_seen_q  <= 1'b0;
      build_cnt_q  <= '0;
      probe_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      build_mask_q <= build_mask_d;
      probe_mask_q <= probe_mask_d;
      last_seen_q  <= last_seen_d;
      build_cnt_q  <= build_cnt_d;
      probe_cnt_q  <= probe_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign phase     = state_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign build_cnt = build_cnt_q;
  assign probe_cnt = probe_cnt_q;

endmodule

// File: tb/tb_phj_phase_sequencer.sv
// Bench for phj_phase_sequencer: instance A uses the default parameters,
// instance B uses DRAIN_CYCLES=0 and CNT_W=4. Expectations are queued with
// the cycle they apply to and checked by a separate negedge monitor.
module tb_phj_phase_sequencer;

  typedef struct {
    string       name;
    int          cyc;
    bit          dut_b;
    bit [2:0]    chk;     // 0: status, 1: counters, 2: gates
    logic [2:0]  phase;
    logic        busy;
    logic        done;
    logic [31:0] bcnt;
    logic [31:0] pcnt;
    logic [7:0]  bov, bir, pov, pir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rst_b, start, abort, olb;
  logic [7:0] biv, bor, piv, por, blp, plp;

  logic [7:0]  a_bir, a_bov, a_pir, a_pov;
  logic [2:0]  a_phase;
  logic        a_busy, a_done;
  logic [31:0] a_bcnt, a_pcnt;

  logic [7:0]  b_bir, b_bov, b_pir, b_pov;
  logic [2:0]  b_phase;
  logic        b_busy, b_done;
  logic [3:0]  b_bcnt, b_pcnt;

  phj_phase_sequencer #(.NUM_PART(8), .CNT_W(32), .DRAIN_CYCLES(16)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start), .abort(abort),
    .build_in_valid(biv), .build_in_ready(a_bir),
    .build_out_valid(a_bov), .build_out_ready(bor),
    .probe_in_valid(piv), .probe_in_ready(a_pir),
    .probe_out_valid(a_pov), .probe_out_ready(por),
    .build_last_processed(blp), .probe_last_processed(plp),
    .out_last_beat(olb), .phase(a_phase), .busy(a_busy), .done(a_done),
    .build_cnt(a_bcnt), .probe_cnt(a_pcnt)
  );

  phj_phase_sequencer #(.NUM_PART(8), .CNT_W(4), .DRAIN_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start), .abort(abort),
    .build_in_valid(biv), .build_in_ready(b_bir),
    .build_out_valid(b_bov), .build_out_ready(bor),
    .probe_in_valid(piv), .probe_in_ready(b_pir),
    .probe_out_valid(b_pov), .probe_out_ready(por),
    .build_last_processed(blp), .probe_last_processed(plp),
    .out_last_beat(olb), .phase(b_phase), .busy(b_busy), .done(b_done),
    .build_cnt(b_bcnt), .probe_cnt(b_pcnt)
  );

  exp_t sb_q[$];
  exp_t me;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sel_b = 1'b0;
  bit   end_chk = 1'b0;

  function automatic exp_t mk(input string nm, input bit [2:0] ck);
    exp_t e;
    e.name = nm;   e.cyc = cyc;   e.dut_b = sel_b; e.chk = ck;
    e.phase = 3'd0; e.busy = 1'b0; e.done = 1'b0;
    e.bcnt = 32'd0; e.pcnt = 32'd0;
    e.bov = 8'd0; e.bir = 8'd0; e.pov = 8'd0; e.pir = 8'd0;
    return e;
  endfunction

  task automatic exp_status(input string nm, input logic [2:0] ph, input logic dn);
    exp_t e;
    e = mk(nm, 3'b001);
    e.phase = ph; e.busy = (ph != 3'd0); e.done = dn;
    sb_q.push_back(e);
  endtask

  task automatic exp_cnt(input string nm, input logic [31:0] bc, input logic [31:0] pc);
    exp_t e;
    e = mk(nm, 3'b010);
    e.bcnt = bc; e.pcnt = pc;
    sb_q.push_back(e);
  endtask

  task automatic exp_gate(input string nm, input logic [7:0] bov, input logic [7:0] bir,
                          input logic [7:0] pov, input logic [7:0] pir);
    exp_t e;
    e = mk(nm, 3'b100);
    e.bov = bov; e.bir = bir; e.pov = pov; e.pir = pir;
    sb_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [2:0]  ph;
    logic        bz, dn;
    logic [31:0] bc, pc;
    logic [7:0]  bov, bir, pov, pir;
    ph  = e.dut_b ? b_phase : a_phase;
    bz  = e.dut_b ? b_busy  : a_busy;
    dn  = e.dut_b ? b_done  : a_done;
    bc  = e.dut_b ? 32'(b_bcnt) : a_bcnt;
    pc  = e.dut_b ? 32'(b_pcnt) : a_pcnt;
    bov = e.dut_b ? b_bov : a_bov;
    bir = e.dut_b ? b_bir : a_bir;
    pov = e.dut_b ? b_pov : a_pov;
    pir = e.dut_b ? b_pir : a_pir;
    vectors++;
    if (e.cyc != cyc) begin
      miscompares++;
      $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end else if (e.chk[0] && (ph !== e.phase || bz !== e.busy || dn !== e.done)) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got phase=%0d busy=%0b done=%0b, want phase=%0d busy=%0b done=%0b",
               e.name, cyc, ph, bz, dn, e.phase, e.busy, e.done);
    end else if (e.chk[1] && (bc !== e.bcnt || pc !== e.pcnt)) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got build_cnt=%0d probe_cnt=%0d, want build_cnt=%0d probe_cnt=%0d",
               e.name, cyc, bc, pc, e.bcnt, e.pcnt);
    end else if (e.chk[2] && (bov !== e.bov || bir !== e.bir || pov !== e.pov || pir !== e.pir)) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got bov=%h bir=%h pov=%h pir=%h, want bov=%h bir=%h pov=%h pir=%h",
               e.name, cyc, bov, bir, pov, pir, e.bov, e.bir, e.pov, e.pir);
    end
  endtask

  // Monitor: consumes every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      me = sb_q.pop_front();
      check(me);
    end
    if (end_chk) begin
      while (sb_q.size() != 0) begin
        me = sb_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL %s: never sampled, got nothing, want cycle %0d", me.name, me.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    biv = 8'h00; bor = 8'h00; piv = 8'h00; por = 8'h00;
    blp = 8'h00; plp = 8'h00; olb = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    sel_b = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    clr_in();
    tick(); tick();
    // Reset holds everything closed even with all inputs active.
    biv = 8'hFF; bor = 8'hFF; piv = 8'hFF; por = 8'hFF; blp = 8'hFF; plp = 8'hFF; olb = 1'b1;
    exp_status("rst_state", 3'd0, 1'b0);
    exp_cnt("rst_cnt", 32'd0, 32'd0);
    exp_gate("rst_gate", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(); rst_a = 1'b0; blp = 8'h00; plp = 8'h00; olb = 1'b0;
    exp_status("idle_state", 3'd0, 1'b0);
    exp_gate("idle_gate", 8'h00, 8'h00, 8'h00, 8'h00);
    tick(); clr_in(); start = 1'b1;
    exp_status("start_cycle", 3'd0, 1'b0);

    // Job 1: full build, 16-cycle drain, probe, flush, done.
    tick(); start = 1'b0; biv = 8'hFF; bor = 8'hFF; piv = 8'hFF; por = 8'hFF;
    exp_status("build_entry", 3'd1, 1'b0);
    exp_cnt("build_cnt0", 32'd0, 32'd0);
    exp_gate("build_gate", 8'hFF, 8'hFF, 8'h00, 8'h00);
    tick(); exp_cnt("build_cnt8", 32'd8, 32'd0);
    tick(); exp_cnt("build_cnt16", 32'd16, 32'd0);
    tick(); blp = 8'hFF;
    exp_cnt("build_cnt24", 32'd24, 32'd0);
    exp_status("build_last", 3'd1, 1'b0);
    tick(); blp = 8'h00;
    exp_status("drain_entry", 3'd2, 1'b0);
    exp_cnt("build_cnt32", 32'd32, 32'd0);
    exp_gate("drain_gate", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 2; i <= 16; i++) begin
      tick();
      exp_status("drain_hold", 3'd2, 1'b0);
      exp_gate("drain_gate_hold", 8'h00, 8'h00, 8'h00, 8'h00);
    end
    tick(); por = 8'h55;
    exp_status("probe_entry", 3'd3, 1'b0);
    exp_gate("probe_gate", 8'h00, 8'h00, 8'hFF, 8'h55);
    tick(); olb = 1'b1; exp_cnt("probe_cnt4", 32'd32, 32'd4);
    tick(); olb = 1'b0; exp_cnt("probe_cnt8", 32'd32, 32'd8);
    tick(); biv = 8'h00; piv = 8'h00; plp = 8'hFF;
    exp_cnt("probe_cnt12", 32'd32, 32'd12);
    exp_status("probe_hold", 3'd3, 1'b0);
    tick(); plp = 8'h00; exp_status("flush", 3'd4, 1'b0);
    tick(); exp_status("done_pulse", 3'd5, 1'b1);
    tick(); exp_status("idle_after_done", 3'd0, 1'b0);
    exp_cnt("cnt_held", 32'd32, 32'd12);
    tick(); exp_status("done_once", 3'd0, 1'b0);

    // Job 2: staggered build completion, then abort in probe.
    tick(); clr_in(); start = 1'b1;
    exp_cnt("cnt_before_start", 32'd32, 32'd12);
    tick(); start = 1'b0;
    exp_status("build2", 3'd1, 1'b0);
    exp_cnt("cnt_cleared", 32'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      blp = (k == 2) ? 8'h0F : ((k == 8) ? 8'hF0 : 8'h00);
      exp_status("stagger_build", 3'd1, 1'b0);
    end
    tick(); blp = 8'h00; exp_status("stagger_drain", 3'd2, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 16) exp_status("drain_last", 3'd2, 1'b0);
    end
    tick(); piv = 8'hFF; por = 8'hFF;
    exp_status("probe2", 3'd3, 1'b0);
    exp_gate("probe2_gate", 8'h00, 8'h00, 8'hFF, 8'hFF);
    tick(); abort = 1'b1;
    exp_gate("abort_gate", 8'h00, 8'h00, 8'h00, 8'h00);
    exp_status("abort_cycle", 3'd3, 1'b0);
    exp_cnt("pre_abort", 32'd0, 32'd8);
    tick(); abort = 1'b0; piv = 8'h00; por = 8'h00;
    exp_status("abort_idle", 3'd0, 1'b0);
    exp_cnt("abort_hold", 32'd0, 32'd8);
    tick(); start = 1'b1; exp_status("abort_no_done", 3'd0, 1'b0);

    // Job 3: fresh job, start ignored in BUILD, reset mid-job.
    tick(); start = 1'b0; biv = 8'hFF; bor = 8'h0F;
    exp_status("fresh_build", 3'd1, 1'b0);
    exp_cnt("fresh_clear", 32'd0, 32'd0);
    exp_gate("partial_ready", 8'hFF, 8'h0F, 8'h00, 8'h00);
    tick(); biv = 8'h00; bor = 8'h00; start = 1'b1;
    exp_cnt("partial_cnt", 32'd4, 32'd0);
    tick(); start = 1'b0;
    exp_status("start_ignored", 3'd1, 1'b0);
    exp_cnt("start_no_clear", 32'd4, 32'd0);
    rst_a = 1'b1;
    tick(); rst_a = 1'b0;
    exp_status("rst_mid", 3'd0, 1'b0);
    exp_cnt("rst_mid_cnt", 32'd0, 32'd0);
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    exp_status("start_abort", 3'd0, 1'b0);

    // Instance B: no drain phase, 4-bit saturating counters.
    sel_b = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    tick(); rst_b = 1'b0;
    exp_status("b_rst", 3'd0, 1'b0);
    exp_cnt("b_rst_cnt", 32'd0, 32'd0);
    tick(); start = 1'b1;
    tick(); start = 1'b0; biv = 8'hFF; bor = 8'hFF;
    exp_status("b_build", 3'd1, 1'b0);
    tick(); blp = 8'h0F; exp_cnt("b_cnt8", 32'd8, 32'd0);
    tick(); blp = 8'h00; exp_cnt("b_sat", 32'd15, 32'd0);
    tick(); biv = 8'h00; start = 1'b1;
    exp_cnt("b_sat_hold", 32'd15, 32'd0);
    tick(); start = 1'b0; biv = 8'hFF;
    exp_status("b_start_ign", 3'd1, 1'b0);
    exp_cnt("b_cnt_kept", 32'd15, 32'd0);
    tick(); biv = 8'h00; blp = 8'hF0;
    exp_cnt("b_sat_hold2", 32'd15, 32'd0);
    exp_status("b_wait", 3'd1, 1'b0);
    tick(); blp = 8'h00;
    exp_status("b_no_drain", 3'd3, 1'b0);
    exp_cnt("b_final", 32'd15, 32'd0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    exp_status("b_abort_idle", 3'd0, 1'b0);

    tick();
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phj_phase_sequencer.md
Name: phj_phase_sequencer

Overview:
- Top-level phase controller for the partitioned hash join pipeline: runs IDLE -> BUILD -> BUILD_DRAIN -> PROBE -> FLUSH -> DONE.
- Gates the 8-lane build and probe tuple streams between the AXI-to-stream converter and the murmur hashers, so probe tuples cannot enter the hash tables before every partition has finished building.
- Counts accepted tuples per phase and reports job completion once the final output beat has left the stream-to-AXI converter.

Parameters:
NUM_PART, 8, number of lanes/partitions (hash tables)
CNT_W, 32, width of tuple counters
DRAIN_CYCLES, 16, idle cycles inserted between build completion and probe enable (0 allowed)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle job start request
abort  in  1  synchronous job abort
build_in_valid  in  NUM_PART  per-lane build valid from converter
build_in_ready  out  NUM_PART  per-lane build ready to converter
build_out_valid  out  NUM_PART  gated build valid to build hasher
build_out_ready  in  NUM_PART  build hasher ready
probe_in_valid  in  NUM_PART  per-lane probe valid from converter
probe_in_ready  out  NUM_PART  per-lane probe ready to converter
probe_out_valid  out  NUM_PART  gated probe valid to probe hasher
probe_out_ready  in  NUM_PART  probe hasher ready
build_last_processed  in  NUM_PART  per-table build-side last indication (level or pulse)
probe_last_processed  in  NUM_PART  per-storage probe-side last indication (level or pulse)
out_last_beat  in  1  high when out_valid & out_ready & out_last at AXI output
phase  out  3  encoded state: IDLE=0 BUILD=1 BUILD_DRAIN=2 PROBE=3 FLUSH=4 DONE=5
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
build_cnt  out  CNT_W  build tuples accepted this job
probe_cnt  out  CNT_W  probe tuples accepted this job

Behaviour:
- Data lines do not pass through this block; only valid/ready are gated.
- Gating is combinational, zero latency:
  - Gate open: out_valid = in_valid, in_ready = out_ready.
  - Gate closed: both forced to 0 on all lanes.
- Build gate is open only in BUILD; probe gate is open only in PROBE. Both are closed in all other states.
- Accepted tuple on a lane = *_out_valid & *_out_ready that cycle. The counter adds popcount of accepted lanes (0..NUM_PART) per cycle and saturates at 2^CNT_W-1.
- Sticky masks, NUM_PART bits each:
  - build_mask |= build_last_processed while in BUILD.
  - probe_mask |= probe_last_processed while in PROBE.
  - last_seen is set by out_last_beat in PROBE or FLUSH.
  - All three clear on entry to BUILD.
- Transitions (registered; phase changes the cycle after the condition):
  - IDLE: start=1 -> BUILD. Counters and masks clear on this edge.
  - BUILD: (build_mask | build_last_processed) all ones -> BUILD_DRAIN, drain counter loaded with DRAIN_CYCLES. If DRAIN_CYCLES=0, go directly to PROBE.
  - BUILD_DRAIN: drain counter decrements each cycle; on the cycle it reads 1 -> PROBE (exactly DRAIN_CYCLES cycles spent in BUILD_DRAIN).
  - PROBE: (probe_mask | probe_last_processed) all ones -> FLUSH.
  - FLUSH: (last_seen | out_last_beat) -> DONE.
  - DONE: done=1 for this cycle only -> IDLE.
- The last-processed bit arriving in the same cycle as a transition check counts toward the check (ORed with the mask).
- Handshakes completing in the transition cycle are counted; the gate closes from the next cycle.
- start is ignored in any state other than IDLE.
- abort (any state): gates close combinationally that cycle. Next state is IDLE with no done pulse; counters hold their values; masks clear.
- abort takes priority over every other transition. Simultaneous start & abort in IDLE -> stay IDLE.
- reset: phase=IDLE, busy=0, done=0, build_cnt=0, probe_cnt=0, masks=0, drain counter=0. All gated outputs are 0 during and after reset until BUILD.
- Reset mid-job returns to IDLE; no partial state survives.
- busy = (phase != IDLE). Counters remain readable in IDLE until the next start.

Test Plan:
- Reset then start; 4 cycles of all 8 lanes valid/ready on build; pulse build_last_processed=0xFF -> build_cnt=32, phase 1->2. After exactly 16 cycles phase=3; probe_out_valid=0 throughout BUILD/BUILD_DRAIN even with probe_in_valid=0xFF.
- Build_last_processed arriving staggered (0x0F in cycle 10, 0xF0 in cycle 20) -> BUILD_DRAIN entered at cycle 21, not before. With DRAIN_CYCLES=0 -> PROBE at cycle 21.
- PROBE with probe_out_ready=0x55 and probe_in_valid=0xFF for 3 cycles -> probe_cnt=12, probe_in_ready=0x55. build_out_valid=0 even with build_in_valid=0xFF.
- out_last_beat asserted during PROBE before probe_mask completes -> after probe_last_processed=0xFF: FLUSH 1 cycle, DONE, done pulse of width 1, then IDLE with counters held.
- abort in PROBE with probe_in_valid=0xFF -> probe_out_valid=0 same cycle, phase=IDLE next cycle, no done pulse. A start 2 cycles later runs a fresh job with counters cleared to 0.
- Saturation (CNT_W=4): 3 cycles × 8 lanes accepted -> build_cnt=15, holds at 15. Start asserted while in BUILD -> ignored, counters not cleared.
